// File: rtl/core_pkg.sv
// ============================================================================
// Module     : core_pkg
// Purpose    : Shared types and constants for the multi-cycle core controller:
//              decoder class enum, one-hot state encoding, trap causes, NOP.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JAL    = 3'd4,
    CLS_JALR   = 3'd5,
    CLS_LUI    = 3'd6,
    CLS_AUIPC  = 3'd7
  } dec_class_e;

  // One-hot controller states
  localparam int         C_ST_W         = 6;
  localparam logic [5:0] C_ST_FETCH     = 6'b000001;
  localparam logic [5:0] C_ST_DECODE    = 6'b000010;
  localparam logic [5:0] C_ST_EXECUTE   = 6'b000100;
  localparam logic [5:0] C_ST_MEMORY    = 6'b001000;
  localparam logic [5:0] C_ST_WRITEBACK = 6'b010000;
  localparam logic [5:0] C_ST_TRAP      = 6'b100000;

  // Trap causes
  localparam logic [3:0] C_CAUSE_IADDR   = 4'd0;
  localparam logic [3:0] C_CAUSE_DADDR   = 4'd1;
  localparam logic [3:0] C_CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] C_CAUSE_FETCH_TO = 4'd3;
  localparam logic [3:0] C_CAUSE_DMEM_TO = 4'd4;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/core_lsu_fmt.sv
// ============================================================================
// Module     : core_lsu_fmt
// Purpose    : Combinational byte-lane formatter for loads and stores.
// Ports      : i_off       byte offset of the access within the data word
//              i_funct3    access size [1:0] (0 byte, 1 half, else word),
//                          bit 2 selects zero-extension for loads
//              i_wdata     store source (low 32 bits of RS2)
//              i_rdata     raw load word from the data memory
//              o_be        store byte enables
//              o_wdata     store data replicated across all lanes
//              o_rdata_ext selected load lane, sign/zero extended to XLEN
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_lsu_fmt #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] i_off,
  input  logic [2:0]                i_funct3,
  input  logic [31:0]               i_wdata,
  input  logic [XLEN-1:0]           i_rdata,
  output logic [XLEN/8-1:0]         o_be,
  output logic [XLEN-1:0]           o_wdata,
  output logic [XLEN-1:0]           o_rdata_ext
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_wext;

  // Bring the addressed lane down to bit 0
  assign w_lane = i_rdata >> {i_off, 3'b000};

  // Word is the widest access; on a 32-bit datapath it needs no extension
  if (XLEN == 32) begin : g_word32
    assign w_wext = w_lane;
  end else begin : g_word64
    assign w_wext = {{(XLEN-32){w_lane[31] & ~i_funct3[2]}}, w_lane[31:0]};
  end

  always_comb begin
    o_be        = '0;
    o_wdata     = '0;
    o_rdata_ext = '0;
    case (i_funct3[1:0])
      2'd0: begin
        o_be        = NB'(1) << i_off;
        o_wdata     = {NB{i_wdata[7:0]}};
        o_rdata_ext = {{(XLEN-8){w_lane[7] & ~i_funct3[2]}}, w_lane[7:0]};
      end
      2'd1: begin
        o_be        = NB'(3) << i_off;
        o_wdata     = {(NB/2){i_wdata[15:0]}};
        o_rdata_ext = {{(XLEN-16){w_lane[15] & ~i_funct3[2]}}, w_lane[15:0]};
      end
      default: begin
        o_be        = NB'(4'hF) << i_off;
        o_wdata     = {(NB/4){i_wdata}};
        o_rdata_ext = w_wext;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/core_mc_ctrl.sv
// ============================================================================
// Module     : core_mc_ctrl
// Purpose    : Multi-cycle core controller FETCH/DECODE/EXECUTE/MEMORY/
//              WRITEBACK with sticky TRAP and memory-ack timeouts.
// Config     : CORE_MISALIGN_TRAP_EN - when defined, misaligned data addresses
//              and jump/branch targets with bit1 set trap in EXECUTE; when
//              undefined they are silently aligned down.
// Ports      : clk/rst            clock, synchronous active-high reset
//              o_i_mem_*/i_i_mem_* instruction fetch handshake
//              o_inst             latched instruction to the decoder
//              i_dec_*            decoder class / funct3 / illegal flag
//              i_rs1/i_rs2/i_imm/i_alu_result/i_br_taken  operand inputs
//              o_d_mem_*/i_d_mem_* data memory handshake
//              o_rf_we/o_rf_wdata register-file write port
//              o_pc/o_trap/o_trap_cause  architectural status
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_mc_ctrl
  import core_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              MEM_WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_i_mem_req,
  output logic [XLEN-1:0]   o_i_mem_addr,
  input  logic              i_i_mem_ack,
  input  logic [31:0]       i_i_mem_in,
  output logic [31:0]       o_inst,
  input  logic [2:0]        i_dec_class,
  input  logic [2:0]        i_dec_funct3,
  input  logic              i_dec_illegal,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic              i_br_taken,
  output logic              o_d_mem_req,
  output logic              o_d_mem_we,
  output logic [XLEN/8-1:0] o_d_mem_be,
  output logic [XLEN-1:0]   o_d_mem_addr,
  output logic [XLEN-1:0]   o_d_mem_data,
  input  logic              i_d_mem_ack,
  input  logic [XLEN-1:0]   i_d_mem_in,
  output logic              o_rf_we,
  output logic [XLEN-1:0]   o_rf_wdata,
  output logic [XLEN-1:0]   o_pc,
  output logic              o_trap,
  output logic [3:0]        o_trap_cause
);

  localparam int NB     = XLEN / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  logic [C_ST_W-1:0] r_state, w_state_nxt;
  logic [3:0]        r_cause, w_cause_nxt;
  logic              r_run;
  logic [WAIT_W-1:0] r_wait;
  logic [XLEN-1:0]   r_pc, r_alu, r_imm, r_pc4, r_pcimm, r_tgt, r_daddr, r_ldata;
  logic [31:0]       r_inst, r_rs2;
  dec_class_e        r_class;
  logic [2:0]        r_funct3;
  logic              r_br_taken;

  dec_class_e      w_class;
  logic            w_ireq, w_timeout, w_is_mem, w_trap_i, w_trap_d;
  logic [OFF_W-1:0] w_amask;
  logic [XLEN-1:0] w_ea, w_pcimm, w_tgt_raw, w_tgt, w_daddr, w_pc_nxt;
  logic [XLEN-1:0] w_st_data, w_ld_data;
  logic [NB-1:0]   w_be;

  assign w_class   = dec_class_e'(i_dec_class);
  assign w_is_mem  = (w_class == CLS_LOAD) || (w_class == CLS_STORE);
  // The request is held off for one cycle after reset so that a stale ack
  // from an access abandoned by reset is never taken as a fetch completion.
  assign w_ireq    = (r_state == C_ST_FETCH) && r_run;
  // Ack in the cycle the count reaches the limit wins over the timeout
  assign w_timeout = (MEM_WAIT_MAX != 0) && (r_wait == WAIT_W'(MEM_WAIT_MAX - 1));

  assign w_ea      = i_rs1 + i_imm;
  assign w_pcimm   = r_pc + i_imm;
  assign w_tgt_raw = (w_class == CLS_JALR) ? {w_ea[XLEN-1:1], 1'b0} : w_pcimm;

  always_comb begin
    case (i_dec_funct3[1:0])
      2'd0:    w_amask = '0;
      2'd1:    w_amask = OFF_W'(1);
      default: w_amask = OFF_W'(3);
    endcase
  end

`ifdef CORE_MISALIGN_TRAP_EN
  logic w_jump;
  assign w_jump   = (w_class == CLS_JAL) || (w_class == CLS_JALR) ||
                    ((w_class == CLS_BRANCH) && i_br_taken);
  assign w_trap_i = w_jump && w_tgt_raw[1];
  assign w_trap_d = w_is_mem && |(w_ea[OFF_W-1:0] & w_amask);
  assign w_tgt    = w_tgt_raw;
  assign w_daddr  = w_ea;
`else
  assign w_trap_i = 1'b0;
  assign w_trap_d = 1'b0;
  assign w_tgt    = {w_tgt_raw[XLEN-1:2], 1'b0, w_tgt_raw[0]};
  assign w_daddr  = {w_ea[XLEN-1:OFF_W], w_ea[OFF_W-1:0] & ~w_amask};
`endif

  core_lsu_fmt #(.XLEN(XLEN)) u_lsu_fmt (
    .i_off       (r_daddr[OFF_W-1:0]),
    .i_funct3    (r_funct3),
    .i_wdata     (r_rs2),
    .i_rdata     (r_ldata),
    .o_be        (w_be),
    .o_wdata     (w_st_data),
    .o_rdata_ext (w_ld_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_ST_FETCH;
      r_cause <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      r_run   <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      C_ST_FETCH: begin
        if (w_ireq && i_i_mem_ack) begin
          w_state_nxt = C_ST_DECODE;
        end else if (w_ireq && w_timeout) begin
          w_state_nxt = C_ST_TRAP;
          w_cause_nxt = C_CAUSE_FETCH_TO;
        end
      end
      C_ST_DECODE: begin
        if (i_dec_illegal) begin
          w_state_nxt = C_ST_TRAP;
          w_cause_nxt = C_CAUSE_ILLEGAL;
        end else begin
          w_state_nxt = C_ST_EXECUTE;
        end
      end
      C_ST_EXECUTE: begin
        if (w_trap_i) begin
          w_state_nxt = C_ST_TRAP;
          w_cause_nxt = C_CAUSE_IADDR;
        end else if (w_trap_d) begin
          w_state_nxt = C_ST_TRAP;
          w_cause_nxt = C_CAUSE_DADDR;
        end else if (w_is_mem) begin
          w_state_nxt = C_ST_MEMORY;
        end else begin
          w_state_nxt = C_ST_WRITEBACK;
        end
      end
      C_ST_MEMORY: begin
        if (i_d_mem_ack) begin
          w_state_nxt = C_ST_WRITEBACK;
        end else if (w_timeout) begin
          w_state_nxt = C_ST_TRAP;
          w_cause_nxt = C_CAUSE_DMEM_TO;
        end
      end
      C_ST_WRITEBACK: w_state_nxt = C_ST_FETCH;
      C_ST_TRAP:      w_state_nxt = C_ST_TRAP;
      default:        w_state_nxt = C_ST_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    o_i_mem_req = w_ireq;
    o_d_mem_req = (r_state == C_ST_MEMORY);
    o_d_mem_we  = (r_state == C_ST_MEMORY) && (r_class == CLS_STORE);
    o_d_mem_be  = (r_state == C_ST_MEMORY) ? w_be : '0;
    o_rf_we     = (r_state == C_ST_WRITEBACK) &&
                  (r_class != CLS_STORE) && (r_class != CLS_BRANCH);
    o_trap      = (r_state == C_ST_TRAP);
    case (r_class)
      CLS_ALU:            o_rf_wdata = r_alu;
      CLS_LOAD:           o_rf_wdata = w_ld_data;
      CLS_LUI:            o_rf_wdata = r_imm;
      CLS_AUIPC:          o_rf_wdata = r_pcimm;
      CLS_JAL, CLS_JALR:  o_rf_wdata = r_pc4;
      default:            o_rf_wdata = '0;
    endcase
  end

  assign o_i_mem_addr = r_pc;
  assign o_d_mem_addr = r_daddr;
  assign o_d_mem_data = w_st_data;
  assign o_inst       = r_inst;
  assign o_pc         = r_pc;
  assign o_trap_cause = r_cause;

  assign w_pc_nxt = (((r_class == CLS_BRANCH) && r_br_taken) ||
                     (r_class == CLS_JAL) || (r_class == CLS_JALR)) ? r_tgt : r_pc4;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inst     <= C_NOP;
      r_wait     <= '0;
      r_class    <= CLS_ALU;
      r_funct3   <= '0;
      r_br_taken <= 1'b0;
      r_alu      <= '0;
      r_imm      <= '0;
      r_pc4      <= '0;
      r_pcimm    <= '0;
      r_tgt      <= '0;
      r_daddr    <= '0;
      r_rs2      <= '0;
      r_ldata    <= '0;
    end else begin
      // Counter restarts on every state change, so it is zero on entry
      if (w_state_nxt != r_state) begin
        r_wait <= '0;
      end else if (w_ireq || (r_state == C_ST_MEMORY)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_ireq && i_i_mem_ack) begin
        r_inst <= i_i_mem_in;
      end
      if (r_state == C_ST_EXECUTE) begin
        r_class    <= w_class;
        r_funct3   <= i_dec_funct3;
        r_br_taken <= i_br_taken;
        r_alu      <= i_alu_result;
        r_imm      <= i_imm;
        r_pc4      <= r_pc + XLEN'(4);
        r_pcimm    <= w_pcimm;
        r_tgt      <= w_tgt;
        r_daddr    <= w_daddr;
        r_rs2      <= i_rs2[31:0];
      end
      if ((r_state == C_ST_MEMORY) && i_d_mem_ack) begin
        r_ldata <= i_d_mem_in;
      end
      if (r_state == C_ST_WRITEBACK) begin
        r_pc <= w_pc_nxt;
      end
    end
  end

endmodule

`default_nettype wire
